// File: rtl/pulse_cmd_sender_if.sv
// Command/UART link bundle for pulse_cmd_sender.
// slave: the sender's view; master: host plus UART core view.
interface pulse_cmd_sender_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_ctrl;
    logic [31:0] cmd_data;
    logic        transmit;
    logic [7:0]  tx_byte;
    logic        is_transmitting;
    logic        received;
    logic [7:0]  rx_byte;
    logic        busy;
    logic        done;
    logic        ack_ok;
    logic        ack_err;
    logic        ack_timeout;
    logic [7:0]  echo_byte;

    modport slave (
        input  cmd_valid, cmd_ctrl, cmd_data,
        input  is_transmitting, received, rx_byte,
        output cmd_ready, transmit, tx_byte,
        output busy, done, ack_ok, ack_err,
        output ack_timeout, echo_byte
    );

    modport master (
        output cmd_valid, cmd_ctrl, cmd_data,
        output is_transmitting, received, rx_byte,
        input  cmd_ready, transmit, tx_byte,
        input  busy, done, ack_ok, ack_err,
        input  ack_timeout, echo_byte
    );
endinterface

// File: rtl/pulse_cmd_sender.sv
// Pulse-parameter command sender: 4 data bytes (LSB first) + ctrl
// byte over a byte UART, then checks the responder's checksum echo.
// Ports: clk, rst_n (async, active low), bus (pulse_cmd_sender_if.slave).
module pulse_cmd_sender #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000,
    parameter logic [7:0]  TXSTART_CYCLES = 8'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    pulse_cmd_sender_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TX_WAITIDLE,
        S_TX_STROBE,
        S_TX_START,
        S_TX_BUSY,
        S_TX_NEXT,
        S_WAIT_ACK,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_data;
    logic [7:0]  r_ctrl;
    logic [7:0]  r_expected;
    logic [2:0]  r_idx;
    logic [7:0]  r_start_cnt;
    logic [31:0] r_to_cnt;
    logic [7:0]  r_tx_byte;
    logic [7:0]  r_echo;
    logic        r_ack_ok;
    logic        r_ack_err;
    logic        r_ack_to;
    logic        r_cmd_ready;
    logic        r_transmit;
    logic        r_busy;
    logic        r_done;

    logic        w_accept;
    logic        w_load;
    logic        w_clr_start;
    logic        w_inc_start;
    logic        w_inc_idx;
    logic        w_clr_to;
    logic        w_inc_to;
    logic        w_rx_hit;
    logic        w_to_hit;
    logic        w_start_expired;
    logic        w_to_expired;
    logic [7:0]  w_sum;
    logic [7:0]  w_sel;

    // Checksum covers only the four data bytes.
    assign w_sum = bus.cmd_data[7:0]   + bus.cmd_data[15:8]
                 + bus.cmd_data[23:16] + bus.cmd_data[31:24];

    assign w_sel = (r_idx == 3'd4) ? r_ctrl
                 : r_data[{r_idx[1:0], 3'b000} +: 8];

    // 9-bit compare so TXSTART_CYCLES=255 cannot wrap.
    assign w_start_expired =
        ({1'b0, r_start_cnt} + 9'd1) >= {1'b0, TXSTART_CYCLES};
    assign w_to_expired = r_to_cnt >= (TIMEOUT_CYCLES - 32'd1);

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_clr_start = 1'b0;
        w_inc_start = 1'b0;
        w_inc_idx   = 1'b0;
        w_clr_to    = 1'b0;
        w_inc_to    = 1'b0;
        w_rx_hit    = 1'b0;
        w_to_hit    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_TX_WAITIDLE;
                end
            end
            S_TX_WAITIDLE: begin
                if (!bus.is_transmitting) begin
                    w_load = 1'b1;
                    w_next = S_TX_STROBE;
                end
            end
            S_TX_STROBE: begin
                w_clr_start = 1'b1;
                w_next      = S_TX_START;
            end
            S_TX_START: begin
                // A core that never raises busy still lets the frame move on.
                if (bus.is_transmitting) begin
                    w_next = S_TX_BUSY;
                end else if (w_start_expired) begin
                    w_next = S_TX_NEXT;
                end else begin
                    w_inc_start = 1'b1;
                end
            end
            S_TX_BUSY: begin
                if (!bus.is_transmitting) begin
                    w_next = S_TX_NEXT;
                end
            end
            S_TX_NEXT: begin
                if (r_idx == 3'd4) begin
                    w_clr_to = 1'b1;
                    w_next   = S_WAIT_ACK;
                end else begin
                    w_inc_idx = 1'b1;
                    w_next    = S_TX_WAITIDLE;
                end
            end
            S_WAIT_ACK: begin
                // An echo arriving on the timeout cycle still counts.
                if (bus.received) begin
                    w_rx_hit = 1'b1;
                    w_next   = S_DONE;
                end else if (w_to_expired) begin
                    w_to_hit = 1'b1;
                    w_next   = S_DONE;
                end else begin
                    w_inc_to = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data      <= '0;
            r_ctrl      <= '0;
            r_expected  <= '0;
            r_idx       <= '0;
            r_start_cnt <= '0;
            r_to_cnt    <= '0;
            r_tx_byte   <= '0;
            r_echo      <= '0;
            r_ack_ok    <= 1'b0;
            r_ack_err   <= 1'b0;
            r_ack_to    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_transmit  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cmd_ready <= (w_next == S_IDLE);
            r_transmit  <= (w_next == S_TX_STROBE);
            r_busy      <= (w_next != S_IDLE);
            r_done      <= (w_next == S_DONE);

            if (w_accept) begin
                r_data     <= bus.cmd_data;
                r_ctrl     <= bus.cmd_ctrl;
                r_expected <= w_sum;
                r_idx      <= 3'd0;
                r_ack_ok   <= 1'b0;
                r_ack_err  <= 1'b0;
                r_ack_to   <= 1'b0;
            end

            if (w_load) begin
                r_tx_byte <= w_sel;
            end

            if (w_clr_start) begin
                r_start_cnt <= '0;
            end else if (w_inc_start) begin
                r_start_cnt <= r_start_cnt + 8'd1;
            end

            if (w_inc_idx) begin
                r_idx <= r_idx + 3'd1;
            end

            if (w_clr_to) begin
                r_to_cnt <= '0;
            end else if (w_inc_to && (r_to_cnt != '1)) begin
                r_to_cnt <= r_to_cnt + 32'd1;
            end

            if (w_rx_hit) begin
                r_echo    <= bus.rx_byte;
                r_ack_ok  <= (bus.rx_byte == r_expected);
                r_ack_err <= (bus.rx_byte != r_expected);
            end

            if (w_to_hit) begin
                r_ack_to <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.transmit    = r_transmit;
    assign bus.tx_byte     = r_tx_byte;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.ack_ok      = r_ack_ok;
    assign bus.ack_err     = r_ack_err;
    assign bus.ack_timeout = r_ack_to;
    assign bus.echo_byte   = r_echo;

endmodule

// File: tb/tb_pulse_cmd_sender.sv
// Bench for pulse_cmd_sender: UART model, byte scoreboard,
// table-driven frames plus timeout, handshake, stall and reset cases.
module tb_pulse_cmd_sender;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  ctrl;
        int          blen;
        logic [7:0]  echo;
        bit          exp_ok;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    pulse_cmd_sender_if bus();

    pulse_cmd_sender #(
        .TIMEOUT_CYCLES(32'd1000),
        .TXSTART_CYCLES(8'd4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int n_strobes = 0;
    int n_strobe_busy = 0;
    int n_unstable = 0;
    int n_ready_busy = 0;
    time t_last_strobe = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp_q[$];
    bit aborting = 1'b0;

    int busy_len = 3;
    bit never_start = 1'b0;
    int u_cnt = 0;

    always @(posedge clk) begin
        if (bus.transmit && !never_start) u_cnt <= busy_len;
        else if (u_cnt > 0) u_cnt <= u_cnt - 1;
    end
    assign bus.is_transmitting = (u_cnt > 0);

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.transmit) begin
            n_strobes++;
            t_last_strobe = $time;
            held = bus.tx_byte;
            if (bus.is_transmitting) n_strobe_busy++;
            chk("sb_byte_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("tx_byte_order", bus.tx_byte, exp_q.pop_front());
        end else if (bus.is_transmitting && rst_n && !aborting) begin
            if (bus.tx_byte !== held) n_unstable++;
        end
    end

    task automatic start_cmd(input logic [31:0] d, input logic [7:0] c);
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_data = d;
        bus.cmd_ctrl = c;
        for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
        exp_q.push_back(c);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        chk("busy_after_accept", bus.busy, 1);
        chk("ready_low_after_accept", bus.cmd_ready, 0);
        @(negedge clk);
        chk("first_strobe_latency", bus.transmit, 1);
    endtask

    task automatic wait_sent(input int base, input bit spam);
        int guard;
        guard = 0;
        while (n_strobes < base + 5 && guard < 5000) begin
            @(negedge clk);
            guard++;
            if (spam) begin
                if (bus.cmd_ready) n_ready_busy++;
                bus.cmd_valid = 1'b1;
                bus.cmd_data = 32'hDEADBEEF ^ guard;
                bus.cmd_ctrl = 8'h04;
            end
        end
        bus.cmd_valid = 1'b0;
        chk("five_strobes", n_strobes - base, 5);
        @(negedge clk);
        guard = 0;
        while (bus.is_transmitting && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_rx(input logic [7:0] e);
        bus.received = 1'b1;
        bus.rx_byte = e;
        @(negedge clk);
        bus.received = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int guard;
        guard = 0;
        while (!bus.done && guard < budget) begin
            @(negedge clk);
            guard++;
        end
        chk("done_seen", bus.done, 1);
    endtask

    task automatic after_done();
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("ready_after_done", bus.cmd_ready, 1);
    endtask

    task automatic run_frame(input vec_t v);
        int base;
        busy_len = v.blen;
        base = n_strobes;
        start_cmd(v.data, v.ctrl);
        wait_sent(base, 1'b0);
        chk("no_done_before_echo", bus.done, 0);
        pulse_rx(v.echo);
        wait_done(20);
        chk("ack_ok", bus.ack_ok, 32'(v.exp_ok));
        chk("ack_err", bus.ack_err, 32'(!v.exp_ok));
        chk("ack_timeout_clear", bus.ack_timeout, 0);
        chk("echo_byte", bus.echo_byte, v.echo);
        after_done();
        chk("sb_drained", exp_q.size(), 0);
    endtask

    vec_t vecs[5];

    initial begin
        int base;
        int guard;
        vec_t v;

        vecs[0] = '{32'h01020304, 8'h07, 1,  8'h00, 1'b0};
        vecs[1] = '{32'h00002710, 8'h01, 3,  8'h37, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 8'h00, 3,  8'hFC, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 8'h00, 10, 8'hFD, 1'b0};
        vecs[4] = '{32'h12345678, 8'h05, 3,  8'h14, 1'b1};

        bus.cmd_valid = 1'b0;
        bus.cmd_data = '0;
        bus.cmd_ctrl = '0;
        bus.received = 1'b0;
        bus.rx_byte = '0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_transmit", bus.transmit, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_echo", bus.echo_byte, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // timeout with late echo
        busy_len = 3;
        base = n_strobes;
        start_cmd(32'h0BADF00D, 8'h04);
        wait_sent(base, 1'b0);
        wait_done(1200);
        chk("timeout_latency", 32'(($time - t_last_strobe) / 10), 1006);
        chk("timeout_flag", bus.ack_timeout, 1);
        chk("timeout_ack_ok", bus.ack_ok, 0);
        chk("timeout_ack_err", bus.ack_err, 0);
        after_done();
        pulse_rx(8'h5A);
        repeat (2) @(negedge clk);
        chk("late_echo_ignored", bus.echo_byte, 8'h14);
        chk("timeout_held", bus.ack_timeout, 1);
        chk("late_echo_no_done", bus.busy, 0);

        // slow UART and command spam while busy
        busy_len = 87;
        base = n_strobes;
        start_cmd(32'h0000C350, 8'h05);
        wait_sent(base, 1'b1);
        pulse_rx(8'h13);
        wait_done(20);
        chk("hs_ack_ok", bus.ack_ok, 1);
        after_done();
        repeat (10) @(negedge clk);
        chk("hs_no_extra_strobes", n_strobes - base, 5);
        chk("hs_ready_low_busy", n_ready_busy, 0);

        // UART that never reports busy
        never_start = 1'b1;
        v = '{32'h00000064, 8'h02, 3, 8'h64, 1'b1};
        run_frame(v);
        never_start = 1'b0;

        // reset in the middle of a frame
        busy_len = 87;
        base = n_strobes;
        start_cmd(32'hA1B2C3D4, 8'h03);
        guard = 0;
        while (n_strobes < base + 2 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_two_bytes", n_strobes - base, 2);
        repeat (10) @(negedge clk);
        aborting = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cmd_ready", bus.cmd_ready, 1);
        chk("abort_transmit", bus.transmit, 0);
        chk("abort_tx_byte", bus.tx_byte, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_ack_ok", bus.ack_ok, 0);
        chk("abort_ack_err", bus.ack_err, 0);
        chk("abort_ack_timeout", bus.ack_timeout, 0);
        chk("abort_echo", bus.echo_byte, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        guard = 0;
        while (bus.is_transmitting && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_no_done", bus.done, 0);
        aborting = 1'b0;
        pulse_rx(8'hAA);
        repeat (2) @(negedge clk);
        chk("stray_rx_echo", bus.echo_byte, 0);
        chk("stray_rx_ack", bus.ack_err, 0);
        chk("stray_rx_idle", bus.busy, 0);
        v = '{32'hA1B2C3D4, 8'h03, 3, 8'hEA, 1'b1};
        run_frame(v);

        chk("no_strobe_while_busy", n_strobe_busy, 0);
        chk("tx_byte_stable", n_unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_cmd_sender.md
Name: pulse_cmd_sender

Overview:
- Host-side initiator for the pulse-parameter command link.
- Accepts one command (32-bit value plus control byte) and serializes it through a byte-level UART core as a 5-byte frame: data bytes LSB first, then the control byte.
- Waits for the responder's checksum echo and compares it against the locally computed sum.
- Used in bench models and in the loop-back controller that drives the pulse generator's period, widths, delay, CPMG, blocking and nutation settings.

Parameters:
TIMEOUT_CYCLES, 32'd2000000, cycles to wait for the echo byte after the control byte finishes transmitting before declaring timeout.
TXSTART_CYCLES, 8'd4, maximum cycles to wait for is_transmitting to rise after a transmit strobe; if it never rises, the byte counts as sent.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high in IDLE only; the command is accepted on cmd_valid & cmd_ready
cmd_ctrl  input  8  control byte (0 delay, 1 period, 2 pulse1, 3 pulse2, 4 block, 5 cpmg, 7 nutation)
cmd_data  input  32  parameter value
transmit  output  1  one-cycle strobe to the UART core
tx_byte  output  8  byte to transmit; held stable from the strobe until the byte completes
is_transmitting  input  1  UART core busy
received  input  1  UART core byte-received strobe
rx_byte  input  8  received byte
busy  output  1  frame in progress (not IDLE)
done  output  1  one-cycle pulse when a frame ends (ok, error or timeout)
ack_ok  output  1  last frame's echo matched; held until the next accept
ack_err  output  1  last frame's echo mismatched; held
ack_timeout  output  1  last frame timed out; held
echo_byte  output  8  last echo received; held

Behaviour:
- Reset (async, rst_n low): state IDLE; cmd_ready=1; transmit=0; tx_byte=0; busy=0; done=0; ack_*=0; echo_byte=0; byte index=0; all counters=0.
- Reset mid-frame aborts immediately: no done pulse; the UART core finishes any byte in flight on its own.
- Accept (IDLE, cmd_valid=1):
  - Latch cmd_data and cmd_ctrl.
  - Compute expected = data[7:0]+data[15:8]+data[23:16]+data[31:24] as an 8-bit sum, modulo 256; the control byte is excluded.
  - Clear ack_ok, ack_err and ack_timeout; set index=0; go to TX_WAITIDLE.
  - cmd_valid outside IDLE is ignored; commands are not queued.
- Byte selection: index 0..3 sends latched data[8*index +: 8]; index 4 sends ctrl.
- TX_WAITIDLE: when is_transmitting=0, load tx_byte and go to TX_STROBE.
- TX_STROBE: transmit=1 for exactly this cycle; go to TX_START and clear the start counter.
- TX_START:
  - is_transmitting=1 goes to TX_BUSY.
  - Otherwise, after TXSTART_CYCLES cycles, go straight to TX_NEXT.
- TX_BUSY: when is_transmitting=0, go to TX_NEXT.
- TX_NEXT:
  - index<4: increment index and go to TX_WAITIDLE.
  - index=4: clear the timeout counter and go to WAIT_ACK.
  - Minimum spacing between strobes is 3 cycles.
- WAIT_ACK:
  - On received=1: capture echo_byte=rx_byte. Set ack_ok=1 if rx_byte==expected, else ack_err=1. Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 without received: set ack_timeout=1 and go to DONE.
  - received and timeout in the same cycle: received wins.
  - received strobes in any state other than WAIT_ACK are discarded and do not affect echo_byte.
  - A received level held high for several cycles counts once, because the state leaves WAIT_ACK on the first cycle.
- DONE: done=1 for one cycle; go to IDLE; cmd_ready returns to 1 on the next cycle.
- Latency: accept to first transmit strobe is 2 cycles when the UART core is idle.
- Counters: the timeout counter is 32 bits and saturates, with no wrap. The start counter is 8 bits.
- Outputs are registered; transmit never asserts while is_transmitting=1 in the same cycle.

Test Plan:
- Period command: cmd_data=0x00002710, cmd_ctrl=0x01, UART model idle. Required: bytes 10,27,00,00,01 in order, 5 transmit strobes, then WAIT_ACK. Model echoes 0x37 -> done pulse, ack_ok=1, echo_byte=0x37.
- Checksum wrap: cmd_data=0xFFFFFFFF, ctrl 0x00. Expected sum is 0xFC; echo 0xFC -> ack_ok=1. Echo 0xFD -> ack_err=1, ack_ok=0.
- Timeout: TIMEOUT_CYCLES=1000, no echo. Required: done pulse exactly 1000 cycles after entering WAIT_ACK, with ack_timeout=1; a late echo afterward is ignored and echo_byte is unchanged.
- Handshake: UART model busy for 87 cycles per byte; cmd_valid re-asserted with a new value while busy. Required: no strobe while is_transmitting=1, tx_byte stable through each byte, the second command ignored, cmd_ready=0 until after done.
- Non-starting UART: is_transmitting never rises. Required: each byte advances after TXSTART_CYCLES, all 5 strobes are issued, then WAIT_ACK.
- Reset mid-frame: rst_n low after byte 2. Required: outputs at reset values immediately (async); the next command restarts at byte 0; a stray received strobe in IDLE is ignored.
